frame_generator_param: RTL and testbench

Parametrised successor of the fixed 16-byte frame generator. It captures a frame payload of `FRAME_LEN` words from a flat input bus and emits it as sync-headed output words. Each frame is a sync word, then the payload, then an optional XOR checksum word. Output uses a valid/ready handshake, and frames can run back-to-back from a queued start or in continuous mode. The block sits between the payload source and the serialiser/line encoder.

---
 rtl/frame_gen_pkg.sv | 17 +
 rtl/frame_xor_accum.sv | 34 +++
 rtl/frame_generator_param.sv | 146 ++++++++++++++
 tb/tb_frame_generator_param.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_gen_pkg.sv
// Shared types and defaults for the sync-headed frame generator.
// Default header codes and sync pattern live here.
package frame_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_CHECK
  } state_t;

  localparam logic [1:0] DEF_SYNC_HDR  = 2'b01;
  localparam logic [1:0] DEF_DATA_HDR  = 2'b10;
  localparam logic [1:0] DEF_CHK_HDR   = 2'b11;
  localparam logic [7:0] DEF_SYNC_WORD = 8'hBC;

endpackage

// File: rtl/frame_xor_accum.sv
// XOR checksum over a captured frame payload.
// The parent decides when to load a new frame and when to clear.
module frame_xor_accum #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        load,
  input  logic [FRAME_LEN*DATA_W-1:0] frame_data,
  output logic [DATA_W-1:0]           chk
);

  logic [DATA_W-1:0] x;

  // fold every payload word of the incoming frame
  always_comb begin
    x = '0;
    for (int i = 0; i < FRAME_LEN; i++)
      x = x ^ frame_data[i*DATA_W +: DATA_W];
  end

  // hold the checksum of the frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      chk <= '0;
    else if (load)
      chk <= x;
    else if (clr)
      chk <= '0;
  end

endmodule

// File: rtl/frame_generator_param.sv
// Emits sync word, payload words and optional checksum
// over a valid/ready stream, with queued or continuous restart.
module frame_generator_param
  import frame_gen_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                FRAME_LEN = 16,
  parameter int                SYNC_W    = 2,
  parameter logic [SYNC_W-1:0] SYNC_HDR  = DEF_SYNC_HDR,
  parameter logic [SYNC_W-1:0] DATA_HDR  = DEF_DATA_HDR,
  parameter logic [SYNC_W-1:0] CHK_HDR   = DEF_CHK_HDR,
  parameter logic [DATA_W-1:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter int                CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        continuous,
  input  logic                        chk_en,
  input  logic [FRAME_LEN*DATA_W-1:0] frame_data_in,
  output logic [SYNC_W+DATA_W-1:0]    out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic [CNT_W-1:0]            frame_count
);

  localparam int IDX_W =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(FRAME_LEN - 1);

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        pend_q, pend_d;
  logic                        chk_en_q;
  logic [FRAME_LEN*DATA_W-1:0] payload_q;
  logic [DATA_W-1:0]           chk_w;
  logic [DATA_W-1:0]           word_sel;
  logic [SYNC_W+DATA_W-1:0]    out_d;
  logic                        xfer, cap, last;

  assign xfer = out_valid && out_ready;

  frame_xor_accum #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN)
  ) u_xor (
    .clk        (clk),
    .reset      (reset),
    .clr        (last && !cap),
    .load       (cap),
    .frame_data (frame_data_in),
    .chk        (chk_w)
  );

  // next state, capture/restart decisions and next output word
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    cap      = 1'b0;
    last     = 1'b0;
    word_sel = '0;
    out_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start || continuous) begin
          state_d = ST_SYNC;
          cap     = 1'b1;
        end
      end
      ST_SYNC: begin
        if (xfer) begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            if (chk_en_q) state_d = ST_CHECK;
            else          last    = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (xfer) last = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (last) begin
      if (pend_q || start || continuous) begin
        state_d = ST_SYNC;
        cap     = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
    if (cap)
      pend_d = 1'b0;
    else if (state_q != ST_IDLE && start)
      pend_d = 1'b1;
    word_sel = payload_q[idx_d*DATA_W +: DATA_W];
    unique case (state_d)
      ST_SYNC:    out_d = {SYNC_HDR, SYNC_WORD};
      ST_PAYLOAD: out_d = {DATA_HDR, word_sel};
      ST_CHECK:   out_d = {CHK_HDR, chk_w};
      default:    out_d = '0;
    endcase
  end

  // state, capture and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      chk_en_q    <= 1'b0;
      payload_q   <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      out_data   <= out_d;
      out_valid  <= (state_d != ST_IDLE);
      busy       <= (state_d != ST_IDLE);
      frame_done <= last;
      if (last)
        frame_count <= frame_count + CNT_W'(1);
      if (cap) begin
        payload_q <= frame_data_in;
        chk_en_q  <= chk_en;
      end
    end
  end

endmodule

// File: tb/tb_frame_generator_param.sv
// Bench for frame_generator_param: fixed vectors, directed
// corner sequences and a random run against a word-queue model.
module tb_frame_generator_param;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         continuous = 1'b0;
  logic         chk_en = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] frame_data_in = '0;
  logic [9:0]   out_data;
  logic         out_valid, busy, frame_done;
  logic [15:0]  frame_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_generator_param dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .continuous    (continuous),
    .chk_en        (chk_en),
    .frame_data_in (frame_data_in),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_count   (frame_count)
  );

  logic [7:0] pay [16] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD,
                           8'hEE, 8'hFF, 8'h01, 8'h02,
                           8'h03, 8'h04, 8'h05, 8'h06,
                           8'h07, 8'h08, 8'h09, 8'h0A};

  // reference model: queue of words still owed by the frame
  logic [9:0]  mq [$];
  bit          m_busy, m_pend, m_done;
  logic [15:0] m_cnt;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_pay();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = pay[i];
    return v;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_busy = 0;
    m_pend = 0;
    m_done = 0;
    m_cnt  = '0;
  endtask

  task automatic m_new_frame();
    logic [7:0] x;
    x = '0;
    mq.push_back({2'b01, 8'hBC});
    for (int i = 0; i < 16; i++) begin
      mq.push_back({2'b10, frame_data_in[i*8 +: 8]});
      x ^= frame_data_in[i*8 +: 8];
    end
    if (chk_en) mq.push_back({2'b11, x});
  endtask

  task automatic m_step();
    bit s_new, done;
    s_new = 0;
    done  = 0;
    if (!m_busy) begin
      s_new = start || continuous;
    end else if (out_ready) begin
      void'(mq.pop_front());
      if (mq.size() == 0) begin
        done  = 1;
        s_new = m_pend || start || continuous;
      end
    end
    if (s_new) m_pend = 0;
    else if (m_busy && start) m_pend = 1;
    if (s_new) begin
      m_new_frame();
      m_busy = 1;
    end else if (done) begin
      m_busy = 0;
    end
    if (done) m_cnt = m_cnt + 16'd1;
    m_done = done;
  endtask

  task automatic tick();
    logic [9:0] ed;
    @(posedge clk);
    m_step();
    #1;
    ed = m_busy ? mq[0] : 10'h0;
    chk("m_valid", out_valid, m_busy);
    chk("m_data", out_data, ed);
    chk("m_busy", busy, m_busy);
    chk("m_done", frame_done, m_done);
    chk("m_count", frame_count, m_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    bit         st;
    bit         rdy;
    bit         e_valid;
    logic [9:0] e_data;
    bit         e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int nv, n255, lowb, nd;
    bit found;
    logic [9:0] lastw;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 10'h1BC, 1'b0, 16'd0};
    for (int i = 0; i < 16; i++)
      tbl[i+1] = '{1'b0, 1'b1, 1'b1, {2'b10, pay[i]},
                   1'b0, 16'd0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 10'h0, 1'b1, 16'd1};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 10'h0, 1'b0, 16'd1};

    // reset state
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 10'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_count", frame_count, 16'd0);
    do_reset();

    // single frame, no checksum
    frame_data_in = pack_pay();
    nv = 0;
    for (int i = 0; i < 19; i++) begin
      start = tbl[i].st;
      out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("t1_valid[%0d]", i), out_valid,
          tbl[i].e_valid);
      chk($sformatf("t1_data[%0d]", i), out_data,
          tbl[i].e_data);
      chk($sformatf("t1_done[%0d]", i), frame_done,
          tbl[i].e_done);
      chk($sformatf("t1_cnt[%0d]", i), frame_count,
          tbl[i].e_cnt);
      if (out_valid) nv++;
    end
    chk("t1_nvalid", nv, 17);

    // single frame with checksum
    do_reset();
    chk_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_en = 1'b0;
    nv = 0;
    lastw = '0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        nv++;
        lastw = out_data;
      end
      tick();
    end
    chk("t2_nvalid", nv, 18);
    chk("t2_lastw", lastw, 10'h31A);
    chk("t2_count", frame_count, 16'd1);

    // stall during payload
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_pre", out_data, 10'h2CC);
    out_ready = 1'b0;
    tick();
    chk("t3_hold1", out_data, 10'h2CC);
    tick();
    chk("t3_hold2", out_data, 10'h2CC);
    out_ready = 1'b1;
    tick();
    chk("t3_next", out_data, 10'h2DD);
    for (int i = 0; i < 20; i++) tick();
    chk("t3_count", frame_count, 16'd1);

    // two starts mid-frame collapse into one queued frame
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    frame_data_in = {16{8'h55}};
    n255 = 0;
    lowb = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid && out_data == 10'h255) n255++;
      if (frame_count < 16'd2 && !busy) lowb++;
      tick();
    end
    chk("t4_n255", n255, 16);
    chk("t4_gap", lowb, 0);
    chk("t4_count", frame_count, 16'd2);
    chk("t4_idle", out_valid, 1'b0);

    // continuous mode for three frames
    do_reset();
    frame_data_in = pack_pay();
    continuous = 1'b1;
    tick();
    nd = 0;
    lowb = 0;
    for (int i = 0; i < 80; i++) begin
      if (frame_done) nd++;
      if (nd >= 2) continuous = 1'b0;
      if (nd < 3 && !busy) lowb++;
      tick();
    end
    continuous = 1'b0;
    chk("t5_frames", nd, 3);
    chk("t5_gap", lowb, 0);
    chk("t5_count", frame_count, 16'd3);
    chk("t5_idle", out_valid, 1'b0);

    // reset in the middle of payload word 5
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_data == 10'h2FF) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t6_found", found, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_data", out_data, 10'h0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", frame_done, 1'b0);
    chk("t6_count", frame_count, 16'd0);
    m_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_sync", out_data, 10'h1BC);
    for (int i = 0; i < 20; i++) tick();
    chk("t6_count2", frame_count, 16'd1);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      out_ready  = ($urandom_range(0, 3) != 0);
      start      = ($urandom_range(0, 9) == 0);
      continuous = ($urandom_range(0, 29) == 0);
      chk_en     = $urandom_range(0, 1) == 1;
      for (int w = 0; w < 4; w++)
        frame_data_in[w*32 +: 32] = $urandom;
      tick();
    end
    start = 1'b0;
    continuous = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("rnd_idle", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
